softmax_row_scheduler: RTL and testbench

SOFTMAX_ROW_SCHEDULER -- requirements
Module: softmax_row_scheduler

---
 rtl/softmax_row_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_softmax_row_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_row_scheduler.sv
// softmax_row_scheduler
//   Shares one in-order, fixed-latency softmax engine among N_REQ row
//   requesters. It picks requesters round-robin and enforces a minimum
//   spacing of MIN_GAP cycles between engine issues. It limits the rows in
//   flight to MAX_INFLIGHT. A small FIFO holds {owner, tag} for each issued
//   row, so every completion can be reported with the row that produced it.
//   A drain request stops new issues and reports when the engine is empty.
//
//   Handshake: a requester raises i_req (with i_tag) and holds it until it
//   sees its bit of o_gnt for one cycle. The grant is taken as soon as it is
//   given; there is no ready/back-pressure on the grant side. The engine
//   receives a one-cycle o_sm_valid issue pulse, and it returns exactly one
//   i_sm_valid pulse per issued row, in issue order.
//
//   Optional macro: SOFTMAX_SCHED_TIMEOUT_EN adds a 16-bit completion
//   watchdog that raises o_err if rows stay in flight with no completion.
//
//   Ports
//     i_clk, i_rst            clock, synchronous active-high reset
//     i_req, i_tag            per-requester request and row tag
//     i_drain                 level: stop issuing, wait for in-flight rows
//     i_sm_valid              engine completion pulse
//     o_gnt                   one-hot grant pulse
//     o_sm_valid, o_sm_sel    engine issue pulse and granted requester index
//     o_done, o_done_req,
//     o_done_tag              completion pulse with owner and tag
//     o_inflight              rows issued and not yet completed
//     o_drained               one-cycle pulse when a drain finishes
//     o_err                   sticky error (completion underflow / watchdog)
//     o_state                 debug view of the FSM state (IDLE=0, GAP=1, DRAIN=2)
module softmax_row_scheduler #(
  parameter int N_REQ        = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int TAG_W        = 4,
  parameter int MIN_GAP      = 3,
  localparam int SEL_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CNT_W       = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_REQ-1:0]            i_req,
  input  logic [N_REQ-1:0][TAG_W-1:0] i_tag,
  input  logic                        i_drain,
  input  logic                        i_sm_valid,
  output logic [N_REQ-1:0]            o_gnt,
  output logic                        o_sm_valid,
  output logic [SEL_W-1:0]            o_sm_sel,
  output logic                        o_done,
  output logic [SEL_W-1:0]            o_done_req,
  output logic [TAG_W-1:0]            o_done_tag,
  output logic [CNT_W-1:0]            o_inflight,
  output logic                        o_drained,
  output logic                        o_err,
  output logic [1:0]                  o_state
);

  localparam int PTR_W = $clog2(MAX_INFLIGHT);
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GAP = 2'd1, ST_DRAIN = 2'd2} state_t;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic             drain_done;   // drained pulse already given in this drain
  logic [SEL_W-1:0] rr_ptr;       // highest-priority requester index
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [SEL_W-1:0] fifo_sel [MAX_INFLIGHT];
  logic [TAG_W-1:0] fifo_tag [MAX_INFLIGHT];

  logic             pick_found;
  logic [SEL_W-1:0] pick_sel;
  logic [SEL_W-1:0] cand;
  logic             issue, pop, underflow, wdog_hit;
  logic [CNT_W-1:0] cnt_next;

  assign o_state = state;

  // Round-robin search, starting at rr_ptr and wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_sel   = '0;
    cand       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = SEL_W'((int'(rr_ptr) + i) % N_REQ);
      if (!pick_found && i_req[cand]) begin
        pick_found = 1'b1;
        pick_sel   = cand;
      end
    end
  end

  assign issue     = (state == ST_IDLE) && !i_drain && pick_found &&
                     (o_inflight < CNT_W'(MAX_INFLIGHT));
  assign pop       = i_sm_valid && (o_inflight != '0);
  assign underflow = i_sm_valid && (o_inflight == '0);

  always_comb begin
    cnt_next = o_inflight;
    if (issue && !pop) cnt_next = o_inflight + CNT_W'(1);
    else if (!issue && pop) cnt_next = o_inflight - CNT_W'(1);
  end

`ifdef SOFTMAX_SCHED_TIMEOUT_EN
  logic [15:0] wdog;
  always_ff @(posedge i_clk) begin
    if (i_rst) wdog <= '0;
    else if (o_inflight == '0 || i_sm_valid) wdog <= '0;
    else if (wdog != 16'hFFFF) wdog <= wdog + 16'd1;
  end
  assign wdog_hit = (wdog == 16'hFFFF);
`else
  assign wdog_hit = 1'b0;
`endif

  // Row bookkeeping storage. It needs no reset: the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (issue) begin
      fifo_sel[wr_ptr] <= pick_sel;
      fifo_tag[wr_ptr] <= i_tag[pick_sel];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      gap_cnt    <= '0;
      drain_done <= 1'b0;
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_gnt      <= '0;
      o_sm_valid <= 1'b0;
      o_sm_sel   <= '0;
      o_done     <= 1'b0;
      o_done_req <= '0;
      o_done_tag <= '0;
      o_inflight <= '0;
      o_drained  <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_gnt      <= issue ? (N_REQ'(1) << pick_sel) : '0;
      o_sm_valid <= issue;
      o_sm_sel   <= issue ? pick_sel : '0;
      o_done     <= pop;
      o_done_req <= pop ? fifo_sel[rd_ptr] : '0;
      o_done_tag <= pop ? fifo_tag[rd_ptr] : '0;
      o_inflight <= cnt_next;
      o_drained  <= 1'b0;
      o_err      <= o_err | underflow | wdog_hit;

      if (issue) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        rr_ptr <= (pick_sel == SEL_W'(N_REQ - 1)) ? '0 : pick_sel + SEL_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

      case (state)
        ST_IDLE: begin
          if (i_drain) begin
            state      <= ST_DRAIN;
            drain_done <= 1'b0;
          end else if (issue && MIN_GAP > 1) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_W'(MIN_GAP - 1);
          end
        end
        ST_GAP: begin
          if (i_drain) begin
            state      <= ST_DRAIN;
            drain_done <= 1'b0;
          end else if (gap_cnt == GAP_W'(1)) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        ST_DRAIN: begin
          // cnt_next is used so the pulse lines up with the last o_done.
          if (!drain_done) begin
            if (cnt_next == '0) begin
              o_drained <= 1'b1;
              if (!i_drain) state <= ST_IDLE;
              else drain_done <= 1'b1;
            end
          end else if (!i_drain) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_row_scheduler.sv
module tb_softmax_row_scheduler;

  // ---------------- clock / reset and DUT signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      req;
  logic [1:0][3:0] tag;
  logic            drain, smv;
  logic [1:0]      gnt;
  logic            sm_valid, done, drained, err;
  logic [0:0]      sm_sel, done_req;
  logic [3:0]      done_tag;
  logic [2:0]      inflight;
  logic [1:0]      state;

  // second instance with MIN_GAP=1 for back-to-back issue
  logic [1:0]      req1;
  logic [1:0][3:0] tag1;
  logic            drain1, smv1;
  logic [1:0]      gnt1;
  logic            sm_valid1, done1, drained1, err1;
  logic [0:0]      sm_sel1, done_req1;
  logic [3:0]      done_tag1;
  logic [2:0]      inflight1;
  logic [1:0]      state1;

  softmax_row_scheduler dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_tag(tag), .i_drain(drain),
    .i_sm_valid(smv), .o_gnt(gnt), .o_sm_valid(sm_valid), .o_sm_sel(sm_sel),
    .o_done(done), .o_done_req(done_req), .o_done_tag(done_tag),
    .o_inflight(inflight), .o_drained(drained), .o_err(err), .o_state(state)
  );

  softmax_row_scheduler #(.MIN_GAP(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_req(req1), .i_tag(tag1), .i_drain(drain1),
    .i_sm_valid(smv1), .o_gnt(gnt1), .o_sm_valid(sm_valid1), .o_sm_sel(sm_sel1),
    .o_done(done1), .o_done_req(done_req1), .o_done_tag(done_tag1),
    .o_inflight(inflight1), .o_drained(drained1), .o_err(err1), .o_state(state1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int drained_seen = 0;
  int rr_model = 0;
  logic [4:0] exp_q[$];   // {requester, tag}

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [4:0] e;
    if (!rst && done) begin
      if (exp_q.size() == 0) check_eq("done_unexpected", 32'(done), 32'd0);
      else begin
        e = exp_q.pop_front();
        check_eq("done_req", 32'(done_req), 32'(e[4]));
        check_eq("done_tag", 32'(done_tag), 32'(e[3:0]));
      end
    end
    if (!rst && drained) drained_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(input logic [1:0] mask);
    for (int i = 0; i < 2; i++) begin
      if (mask[(rr_model + i) % 2]) return (rr_model + i) % 2;
    end
    return 0;
  endfunction

  // Record a grant seen now against the model; requests were driven by 'mask'.
  task automatic expect_grant(input string name, input logic [1:0] mask);
    int s;
    logic [1:0] one = 2'b01;
    s = model_pick(mask);
    check_eq({name, "_gnt"}, 32'(gnt), 32'(one << s));
    check_eq({name, "_sel"}, 32'(sm_sel), 32'(s));
    exp_q.push_back({s[0], tag[s]});
    rr_model = (s + 1) % 2;
  endtask

  task automatic issue_row(input logic [1:0] mask, input logic [3:0] t0, input logic [3:0] t1);
    int waited = 0;
    tag[0] = t0;
    tag[1] = t1;
    req = mask;
    do begin
      step();
      waited++;
    end while (!sm_valid && waited < 12);
    check_eq("issue_seen", 32'(sm_valid), 32'd1);
    if (sm_valid) expect_grant("issue", mask);
    req = 2'b00;
  endtask

  task automatic complete_one();
    smv = 1'b1;
    step();
    smv = 1'b0;
    check_eq("complete_done", 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq({name, "_gnt"}, 32'(gnt), 32'd0);
    check_eq({name, "_smv"}, 32'(sm_valid), 32'd0);
    check_eq({name, "_sel"}, 32'(sm_sel), 32'd0);
    check_eq({name, "_done"}, 32'(done), 32'd0);
    check_eq({name, "_dreq"}, 32'(done_req), 32'd0);
    check_eq({name, "_dtag"}, 32'(done_tag), 32'd0);
    check_eq({name, "_infl"}, 32'(inflight), 32'd0);
    check_eq({name, "_drained"}, 32'(drained), 32'd0);
    check_eq({name, "_err"}, 32'(err), 32'd0);
    check_eq({name, "_state"}, 32'(state), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, last, waited;
    logic [1:0] exp_g[3];
    logic [3:0] r0, r1;

    rst = 1'b1; req = '0; tag = '0; drain = 1'b0; smv = 1'b0;
    req1 = '0; tag1 = '0; drain1 = 1'b0; smv1 = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check_reset_outputs("reset");

    // MIN_GAP=1: back-to-back issues, then issue + completion in one cycle
    req1 = 2'b01; tag1[0] = 4'd1;
    step();
    check_eq("b2b_first", 32'(sm_valid1), 32'd1);
    tag1[0] = 4'd2;
    step();
    check_eq("b2b_second", 32'(gnt1), 32'd1);
    req1 = 2'b00;
    step();
    check_eq("b2b_inflight", 32'(inflight1), 32'd2);
    req1 = 2'b01; tag1[0] = 4'd3; smv1 = 1'b1;
    step();
    req1 = 2'b00; smv1 = 1'b0;
    check_eq("same_cycle_gnt", 32'(gnt1), 32'd1);
    check_eq("same_cycle_done", 32'(done1), 32'd1);
    check_eq("same_cycle_dtag", 32'(done_tag1), 32'd1);
    check_eq("same_cycle_infl", 32'(inflight1), 32'd2);

    // Round-robin with MIN_GAP=3: grants 01,10,01 spaced 3 cycles
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    tag[0] = 4'd5; tag[1] = 4'd9; req = 2'b11;
    n = 0; last = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      step();
      if (sm_valid) begin
        check_eq("rr_order", 32'(gnt), 32'(exp_g[n]));
        if (n > 0) check_eq("rr_spacing", 32'(c - last), 32'd3);
        expect_grant("rr", 2'b11);
        last = c;
        n++;
        if (n == 3) req = 2'b00;
      end
    end
    check_eq("rr_count", 32'(n), 32'd3);
    step();
    check_eq("rr_inflight", 32'(inflight), 32'd3);
    repeat (3) complete_one();
    step();
    check_eq("rr_drained_infl", 32'(inflight), 32'd0);

    // In-order completions with tags 3,7,11
    issue_row(2'b01, 4'd3, 4'd0);
    issue_row(2'b10, 4'd0, 4'd7);
    issue_row(2'b01, 4'd11, 4'd0);
    repeat (2) step();
    repeat (3) begin
      complete_one();
      step();
    end

    // Full window: 4 issues, then stall until a completion
    r0 = 4'($urandom_range(0, 15));
    r1 = 4'($urandom_range(0, 15));
    tag[0] = r0; tag[1] = r1; req = 2'b11;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (sm_valid) begin
        expect_grant("full", 2'b11);
        n++;
      end
    end
    check_eq("full_issues", 32'(n), 32'd4);
    check_eq("full_inflight", 32'(inflight), 32'd4);
    smv = 1'b1;
    step();
    smv = 1'b0;
    check_eq("full_done", 32'(done), 32'd1);
    check_eq("full_no_early_gnt", 32'(sm_valid), 32'd0);
    step();
    check_eq("fifth_grant", 32'(sm_valid), 32'd1);
    if (sm_valid) expect_grant("fifth", 2'b11);
    req = 2'b00;
    step();
    check_eq("fifth_inflight", 32'(inflight), 32'd4);
    repeat (4) complete_one();
    step();

    // Drain with 3 rows in flight
    issue_row(2'b11, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    issue_row(2'b11, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    issue_row(2'b11, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    drain = 1'b1; req = 2'b11; drained_seen = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("drain_no_gnt", 32'(sm_valid), 32'd0);
    end
    complete_one();
    complete_one();
    check_eq("drain_early", 32'(drained), 32'd0);
    complete_one();
    check_eq("drain_pulse", 32'(drained), 32'd1);
    step();
    check_eq("drain_pulse_end", 32'(drained), 32'd0);
    step();
    check_eq("drain_hold_no_gnt", 32'(sm_valid), 32'd0);
    drain = 1'b0;
    waited = 0;
    do begin
      step();
      waited++;
    end while (!sm_valid && waited < 8);
    check_eq("drain_resume", 32'(sm_valid), 32'd1);
    if (sm_valid) expect_grant("resume", 2'b11);
    req = 2'b00;
    check_eq("drain_pulse_count", 32'(drained_seen), 32'd1);
    step();
    complete_one();
    step();

    // Completion underflow and reset during activity
    smv = 1'b1;
    step();
    smv = 1'b0;
    check_eq("underflow_err", 32'(err), 32'd1);
    check_eq("underflow_no_done", 32'(done), 32'd0);
    repeat (3) step();
    check_eq("err_sticky", 32'(err), 32'd1);
    issue_row(2'b10, 4'd0, 4'hA);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    rr_model = 0;
    check_reset_outputs("midreset");
    smv = 1'b1;
    step();
    smv = 1'b0;
    check_eq("post_reset_err", 32'(err), 32'd1);
    check_eq("post_reset_no_done", 32'(done), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("err_cleared", 32'(err), 32'd0);
    // round-robin pointer back at requester 0
    issue_row(2'b11, 4'd4, 4'd6);
    step();
    complete_one();
    step();

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
